microsequencer: RTL and testbench

- Next-state controller for the microprogrammed control unit.
- Owns the registered microprogram state and computes the 10-bit next_state that drives the microstore address, from the next-state fields of the current microinstruction.
- Supports increment, jump, conditional branch, instruction dispatch, memory-wait (MOC handshake) and micro-subroutine call/return.
- Sits between the microstore output word and the microstore next_state input.

---
 rtl/microsequencer_pkg.sv | 20 ++
 rtl/microsequencer_return_stack.sv | 61 ++++++
 rtl/microsequencer.sv | 109 ++++++++++
 tb/tb_microsequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/microsequencer_pkg.sv
// Shared control-unit constants: state width, next-state (n_sel) and condition (cond_sel) encodings.
package microsequencer_pkg;

  localparam int STATE_W = 10;

  localparam logic [2:0] NS_DISPATCH = 3'b000;
  localparam logic [2:0] NS_INC      = 3'b001;
  localparam logic [2:0] NS_JUMP     = 3'b010;
  localparam logic [2:0] NS_CBR      = 3'b011;
  localparam logic [2:0] NS_MWAIT    = 3'b100;
  localparam logic [2:0] NS_CALL     = 3'b101;
  localparam logic [2:0] NS_RET      = 3'b110;
  localparam logic [2:0] NS_FETCH    = 3'b111;

  localparam logic [1:0] CS_Z = 2'b00;
  localparam logic [1:0] CS_N = 2'b01;
  localparam logic [1:0] CS_C = 2'b10;
  localparam logic [1:0] CS_V = 2'b11;

endpackage

// File: rtl/microsequencer_return_stack.sv
// LIFO of return addresses for micro-subroutine calls, with sticky overflow/underflow flags.
module microseq_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             ovf_q, ovf_d, unf_q, unf_d;

  assign full      = (ptr_q == PTR_W'(DEPTH));
  assign empty     = (ptr_q == '0);
  assign top_ptr   = ptr_q - 1'b1;
  assign top_data  = mem_q[top_ptr[IDX_W-1:0]];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // A push on a full stack drops the entry; a pop on an empty one leaves the pointer alone.
  always_comb begin
    ptr_d = ptr_q;
    mem_d = mem_q;
    ovf_d = ovf_q | (push & full);
    unf_d = unf_q | (pop & empty);
    if (push && !full) begin
      mem_d[ptr_q[IDX_W-1:0]] = push_data;
      ptr_d = ptr_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      mem_q <= '{default: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram next-state controller. Define MSEQ_STACK_EN to build in the call/return stack;
// without it, call behaves as jump and return as fetch.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int                 STACK_DEPTH   = 4,
  parameter logic [STATE_W-1:0] FETCH_STATE   = 10'd1,
  parameter logic [STATE_W-1:0] DISPATCH_BASE = 10'd10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic               cond_z,
  input  logic               cond_n,
  input  logic               cond_c,
  input  logic               cond_v,
  input  logic               moc,
  input  logic [5:0]         ir_opcode,
  output logic [STATE_W-1:0] next_state,
  output logic [STATE_W-1:0] current_state,
  output logic               stk_overflow,
  output logic               stk_underflow
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("microsequencer: STACK_DEPTH must be a power of 2 in 2..16");
  end

  logic [STATE_W-1:0] current_state_q, current_state_d;
  logic [STATE_W-1:0] inc, dispatch, ns;
  logic               cond_raw, cond;

`ifdef MSEQ_STACK_EN
  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [STATE_W-1:0] stk_top;

  microseq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (STATE_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );
`else
  assign stk_overflow  = 1'b0;
  assign stk_underflow = 1'b0;
`endif

  // Memory wait is a level handshake: the state holds while moc=0 and advances in the cycle moc=1.
  always_comb begin
    cond_raw = cond_z;
    unique case (cond_sel)
      CS_Z: cond_raw = cond_z;
      CS_N: cond_raw = cond_n;
      CS_C: cond_raw = cond_c;
      CS_V: cond_raw = cond_v;
    endcase
    cond     = cond_raw ^ inv;
    inc      = current_state_q + 1'b1;
    dispatch = DISPATCH_BASE + {2'b00, ir_opcode, 2'b00};
    ns       = inc;
`ifdef MSEQ_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    unique case (n_sel)
      NS_DISPATCH: ns = dispatch;
      NS_INC:      ns = inc;
      NS_JUMP:     ns = cr;
      NS_CBR:      ns = cond ? cr : inc;
      NS_MWAIT:    ns = moc ? inc : current_state_q;
`ifdef MSEQ_STACK_EN
      NS_CALL: begin
        stk_push = 1'b1;
        ns       = cr;
      end
      NS_RET: begin
        stk_pop = 1'b1;
        ns      = stk_empty ? FETCH_STATE : stk_top;
      end
`else
      NS_CALL:     ns = cr;
      NS_RET:      ns = FETCH_STATE;
`endif
      NS_FETCH:    ns = FETCH_STATE;
    endcase
    next_state      = reset ? '0 : ns;
    current_state_d = next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) current_state_q <= '0;
    else       current_state_q <= current_state_d;
  end

  assign current_state = current_state_q;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus random micro-ops against a queue-based model.
module tb_microsequencer;
  import microsequencer_pkg::*;

  localparam int SD    = 4;
  localparam int FETCH = 1;
  localparam int DBASE = 10;
  localparam int W     = 22;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] n_sel = NS_FETCH;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'b00;
  logic [9:0] cr = '0;
  logic       cond_z = 1'b0, cond_n = 1'b0, cond_c = 1'b0, cond_v = 1'b0;
  logic       moc = 1'b0;
  logic [5:0] ir_opcode = '0;
  logic [9:0] next_state, current_state;
  logic       stk_overflow, stk_underflow;

  microsequencer #(
    .STACK_DEPTH   (SD),
    .FETCH_STATE   (10'(FETCH)),
    .DISPATCH_BASE (10'(DBASE))
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .n_sel         (n_sel),
    .inv           (inv),
    .cond_sel      (cond_sel),
    .cr            (cr),
    .cond_z        (cond_z),
    .cond_n        (cond_n),
    .cond_c        (cond_c),
    .cond_v        (cond_v),
    .moc           (moc),
    .ir_opcode     (ir_opcode),
    .next_state    (next_state),
    .current_state (current_state),
    .stk_overflow  (stk_overflow),
    .stk_underflow (stk_underflow)
  );

  // reference model state
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int m_state = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic model_reset();
    m_state = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Predict this cycle's outputs from the inputs just driven, then advance the model.
  task automatic predict();
    int inc;
    int nxt;
    bit c;
    bit [3:0] flg;
    inc = (m_state + 1) % 1024;
    flg = {cond_v, cond_c, cond_n, cond_z};
    c   = flg[cond_sel] ^ inv;
    exp_q.push_back({m_ovf, m_unf, 10'(m_state), 10'(0)});
    case (n_sel)
      NS_DISPATCH: nxt = (DBASE + 4 * int'(ir_opcode)) % 1024;
      NS_INC:      nxt = inc;
      NS_JUMP:     nxt = int'(cr);
      NS_CBR:      nxt = c ? int'(cr) : inc;
      NS_MWAIT:    nxt = moc ? inc : m_state;
`ifdef MSEQ_STACK_EN
      NS_CALL: begin
        if (m_stk.size() < SD) m_stk.push_back(inc);
        else m_ovf = 1'b1;
        nxt = int'(cr);
      end
      NS_RET: begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else begin
          m_unf = 1'b1;
          nxt = FETCH;
        end
      end
`else
      NS_CALL:     nxt = int'(cr);
      NS_RET:      nxt = FETCH;
`endif
      default:     nxt = FETCH;
    endcase
    exp_q[exp_q.size()-1][9:0] = 10'(nxt);
    m_state = nxt;
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] ns, input logic [9:0] c, input logic [1:0] cs,
                       input logic iv, input logic [3:0] flg, input logic mc, input logic [5:0] op);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_sel = ns;
    cr = c;
    cond_sel = cs;
    inv = iv;
    {cond_v, cond_c, cond_n, cond_z} = flg;
    moc = mc;
    ir_opcode = op;
    predict();
  endtask

  task automatic op(input logic [2:0] ns, input logic [9:0] c);
    drive(ns, c, 2'b00, 1'b0, 4'b0000, 1'b0, 6'd0);
  endtask

  // Assert reset part-way through a cycle; it stays high until the next drive.
  task automatic reset_mid();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_sel = NS_INC;
    #2;
    reset = 1'b1;
    model_reset();
    exp_q.push_back('0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {stk_overflow, stk_underflow, current_state, next_state};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL step t=%0t ovf/unf/cur/next got %0b/%0b/%0d/%0d want %0b/%0b/%0d/%0d",
                 $time, act_v[21], act_v[20], act_v[19:10], act_v[9:0],
                 exp_v[21], exp_v[20], exp_v[19:10], exp_v[9:0]);
      end
    end
  end

  initial begin
    // reset held: next_state must read 0 even with fetch selected
    @(posedge clk);
    #1;
    exp_q.push_back('0);

    drive(NS_DISPATCH, 10'd0, 2'b00, 1'b0, 4'b0000, 1'b0, 6'd5);
    drive(NS_DISPATCH, 10'd0, 2'b00, 1'b0, 4'b0000, 1'b0, 6'd63);
    op(NS_JUMP, 10'd7);
    drive(NS_CBR, 10'd200, CS_N, 1'b0, 4'b0010, 1'b0, 6'd0);
    op(NS_JUMP, 10'd7);
    drive(NS_CBR, 10'd200, CS_N, 1'b1, 4'b0010, 1'b0, 6'd0);
    op(NS_JUMP, 10'd1023);
    op(NS_INC, 10'd0);

    op(NS_JUMP, 10'd50);
    repeat (3) drive(NS_MWAIT, 10'd0, 2'b00, 1'b0, 4'b0000, 1'b0, 6'd0);
    drive(NS_MWAIT, 10'd0, 2'b00, 1'b0, 4'b0000, 1'b1, 6'd0);
    op(NS_INC, 10'd0);

    op(NS_JUMP, 10'd20);
    op(NS_CALL, 10'd100);
    op(NS_CALL, 10'd150);
    op(NS_RET, 10'd0);
    op(NS_RET, 10'd0);
    op(NS_INC, 10'd0);

    for (int i = 0; i < 5; i++) op(NS_CALL, 10'(300 + 10 * i));
    op(NS_INC, 10'd0);

    reset_mid();
    op(NS_CALL, 10'd60);
    op(NS_CALL, 10'd37);
    reset_mid();
    op(NS_RET, 10'd0);
    op(NS_INC, 10'd0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) reset_mid();
      else drive(3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)));
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
